gray_encoder_counter: RTL
=========================

Name: gray_encoder_counter

Overview:
Registered binary-to-Gray encoder with an integrated up/down Gray counter. It is the encode-side companion of the team's Gray-to-binary decoder. It accepts binary values over a valid/ready load interface, or steps an internal count, and presents the result as a registered Gray code. The output is intended for Gray-coded pointers and position words that are later decoded back to binary.

Parameters:
WIDTH, 4, bit width of binary input, internal count and Gray output (min 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
load_valid  input  1  bin_in is valid this cycle
load_ready  output  1  block accepts a load this cycle
bin_in  input  WIDTH  binary value to load
cnt_en  input  1  request one count step this cycle
cnt_up  input  1  step direction: 1 = increment, 0 = decrement
gray_out  output  WIDTH  registered Gray code of the internal binary count
bin_out  output  WIDTH  registered internal binary count (debug/verification)
gray_valid  output  1  gray_out holds a meaningful value
wrap  output  1  one-cycle pulse: the last count step wrapped around
state_out  output  2  FSM state: 0 = IDLE, 1 = COUNT, 2 = SETTLE

Behaviour:
- Reset (rst = 1 at the clk edge):
  - bin_out = 0, gray_out = 0, gray_valid = 0, wrap = 0.
  - state = IDLE, load_ready = 1.
  - Reset overrides every other input, including in the middle of a load or a count.
- Encoding rule: gray_out = b ^ (b >> 1), where b is the internal count.
  - gray_out is registered from the next value of b on the same edge that updates b, so gray_out and bin_out always match in the same cycle.
  - No combinational path exists from any input to gray_out.
- load_ready = 1 in IDLE and COUNT, 0 in SETTLE. It is a function of state only and does not depend on load_valid.
- Load fire is load_valid & load_ready at the edge. On a fire:
  - b <= bin_in, gray_out <= bin_in ^ (bin_in >> 1), gray_valid <= 1, wrap <= 0.
  - The next state is SETTLE.
  - Latency is 1 cycle from the fire edge to the new gray_out.
- Count step occurs when cnt_en = 1, there is no load fire, and state != SETTLE.
  - cnt_up = 1: b <= b + 1 mod 2^WIDTH. cnt_up = 0: b <= b - 1 mod 2^WIDTH.
  - gray_out updates on the same edge; gray_valid <= 1; next state is COUNT.
- Wrap:
  - wrap <= 1 on an increment step from all-ones to 0, or on a decrement step from 0 to all-ones.
  - Otherwise wrap <= 0, so it is a single-cycle pulse.
  - A load never asserts wrap.
- FSM transitions:
  - IDLE: load fire -> SETTLE; else step -> COUNT; else stay IDLE.
  - COUNT: load fire -> SETTLE; else step -> COUNT; else -> IDLE.
  - SETTLE: lasts exactly one cycle, then goes to IDLE. Loads and steps are both suppressed, and b holds. A cnt_en held high resumes stepping from the following cycle.
- Simultaneous load fire and cnt_en: the load wins, the step is dropped entirely and is not deferred.
- Hold: with no fire and no step, b, gray_out and gray_valid hold; wrap = 0.
- Invariant: two consecutive count steps with no intervening load change gray_out in exactly one bit, including across the wrap.
- load_valid while load_ready = 0 is ignored. The source must hold the value until it sees ready.

Test Plan:
- Reset, then load bin_in = 4'b1011 -> next cycle gray_out = 4'b1110, bin_out = 11, gray_valid = 1, state = SETTLE, load_ready = 0; one cycle later state = IDLE, load_ready = 1.
- After that load, cnt_en = 1, cnt_up = 1 for 3 cycles (first step lands the cycle after SETTLE) -> bin_out = 12, 13, 14; gray_out = 1010, 1011, 1001; each successive gray_out differs in one bit.
- Load 15 (gray_out = 1000), then one increment -> bin_out = 0, gray_out = 0000, wrap = 1 for exactly one cycle; one decrement from 0 -> bin_out = 15, gray_out = 1000, wrap = 1.
- load_valid = 1 with bin_in = 5 and cnt_en = 1 on the same edge, from bin_out = 9 -> bin_out = 5, gray_out = 0111, wrap = 0, state = SETTLE; cnt_en held high: no step during SETTLE, then bin_out = 6.
- load_valid held during SETTLE with bin_in changed to 2 -> the value is ignored until load_ready returns, then accepted: bin_out = 2, gray_out = 0011.
- Free-running increment for 20 cycles, then rst = 1 mid-count -> next cycle all outputs at their reset values, state = IDLE; a full 16-step up-count sweep checks the one-bit-change invariant on every step.

Source files
------------

// File: rtl/gray_encoder_counter.sv
// Registered binary-to-Gray encoder with an integrated up/down counter.
// A load sets the count from bin_in; count steps move it by one; gray_out tracks it.
module gray_encoder_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             cnt_en,
    input  logic             cnt_up,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             gray_valid,
    output logic             wrap,
    output logic [1:0]       state_out
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             gray_valid_q, gray_valid_d;
    logic             wrap_q, wrap_d;
    logic             fire, step;

    // A load takes priority; a step coinciding with a load is dropped.
    always_comb begin
        fire = load_valid & load_ready;
        step = cnt_en & ~fire & (state_q != S_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE, S_COUNT: begin
                if (fire)      state_d = S_SETTLE;
                else if (step) state_d = S_COUNT;
                else           state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q != S_SETTLE);
        state_out  = state_q;
    end

    always_comb begin
        bin_d        = bin_q;
        gray_valid_d = gray_valid_q;
        wrap_d       = 1'b0;
        if (fire) begin
            bin_d        = bin_in;
            gray_valid_d = 1'b1;
        end else if (step) begin
            gray_valid_d = 1'b1;
            if (cnt_up) begin
                bin_d  = bin_q + 1'b1;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - 1'b1;
                wrap_d = ~|bin_q;
            end
        end
        // Encode the next count so gray and binary land on the same edge.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q        <= '0;
            gray_q       <= '0;
            gray_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            bin_q        <= bin_d;
            gray_q       <= gray_d;
            gray_valid_q <= gray_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    always_comb begin
        bin_out    = bin_q;
        gray_out   = gray_q;
        gray_valid = gray_valid_q;
        wrap       = wrap_q;
    end

endmodule
